// File: rtl/uart_tx_sched_if.sv
// Requester and serializer signals shared by the UART transmit scheduler.
// The master modport is the scheduler side; slave is the requester/serializer side.
interface uart_tx_sched_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         tx_data;
  logic                     tx_start_n;
  logic                     tx_busy;

  modport master (
    input  req, req_data, tx_busy,
    output ack, tx_data, tx_start_n
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, tx_data, tx_start_n
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin arbiter feeding one UART serializer. Grants one edge after req is seen in IDLE.
// Requesters hold req/data until ack; no grant while tx_busy is high, en is low or a transfer is in flight.
module uart_tx_sched #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TO_CYC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  uart_tx_sched_if.master  bus,
  output logic             active,
  output logic [ID_W-1:0]  cur_id,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic             to_err,
  input  logic             err_clr
);
  localparam int CNT_W = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     tx_data_q, tx_data_d;
  logic [ID_W-1:0]      cur_id_q, cur_id_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 tx_start_n_q, tx_start_n_d;
  logic                 done_q, done_d;
  logic [ID_W-1:0]      done_id_q, done_id_d;
  logic                 to_err_q, to_err_d;

  logic [WIDTH-1:0]     words [NUM_REQ];
  logic                 grant_vld;
  logic [ID_W-1:0]      win_id;
  int                   scan_idx;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan ptr, ptr+1, ... wrapping at NUM_REQ; the first set request wins.
  always_comb begin
    grant_vld = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      if (!grant_vld && bus.req[ID_W'(scan_idx)]) begin
        grant_vld = 1'b1;
        win_id    = ID_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    cur_id_d     = cur_id_q;
    ack_d        = '0;
    tx_start_n_d = 1'b1;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    to_err_d     = err_clr ? 1'b0 : to_err_q;

    unique case (state_q)
      IDLE: begin
        if (en && !bus.tx_busy && grant_vld) begin
          tx_data_d       = words[win_id];
          cur_id_d        = win_id;
          ack_d[win_id]   = 1'b1;
          tx_start_n_d    = 1'b0;
          ptr_d           = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
          state_d         = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(TO_CYC-1)) begin
          // Serializer never acknowledged: drop the word, flag it, and close the transfer.
          to_err_d  = 1'b1;
          done_d    = 1'b1;
          done_id_d = cur_id_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_d    = 1'b1;
          done_id_d = cur_id_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      cur_id_q     <= '0;
      ack_q        <= '0;
      tx_start_n_q <= 1'b1;
      done_q       <= 1'b0;
      done_id_q    <= '0;
      to_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      cur_id_q     <= cur_id_d;
      ack_q        <= ack_d;
      tx_start_n_q <= tx_start_n_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      to_err_q     <= to_err_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start_n = tx_start_n_q;
  assign active         = (state_q != IDLE);
  assign cur_id         = cur_id_q;
  assign done           = done_q;
  assign done_id        = done_id_q;
  assign to_err         = to_err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural serializer (busy for 34 cycles after start).
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_uart_tx_sched;
  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TO_CYC  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            err_clr;
  logic            active;
  logic [ID_W-1:0] cur_id;
  logic            done;
  logic [ID_W-1:0] done_id;
  logic            to_err;

  logic model_busy;
  logic force_busy;
  logic model_on;
  int   bcnt;

  int n_chk;
  int n_pass;
  int ack_cnt;
  int done_cnt;
  int bad_ack;

  uart_tx_sched_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  assign bus.tx_busy = model_busy | force_busy;

  uart_tx_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TO_CYC(TO_CYC)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bus     (bus),
    .active  (active),
    .cur_id  (cur_id),
    .done    (done),
    .done_id (done_id),
    .to_err  (to_err),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  // Serializer: busy rises in the start cycle and falls 34 cycles later.
  initial begin
    model_busy = 1'b0;
    bcnt       = 0;
    forever begin
      @(posedge clk);
      #2;
      if (model_on && bus.tx_start_n == 1'b0) begin
        model_busy = 1'b1;
        bcnt       = 34;
      end else if (bcnt > 0) begin
        bcnt = bcnt - 1;
        if (bcnt == 0) model_busy = 1'b0;
      end
    end
  end

  initial begin
    ack_cnt  = 0;
    done_cnt = 0;
    bad_ack  = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (bus.ack != '0) begin
          ack_cnt = ack_cnt + 1;
          if (!$onehot(bus.ack) || bus.tx_start_n) bad_ack = bad_ack + 1;
        end
        if (bus.tx_start_n == 1'b0 && bus.ack == '0) bad_ack = bad_ack + 1;
        if (done) done_cnt = done_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int enc(input logic [NUM_REQ-1:0] a);
    for (int i = 0; i < NUM_REQ; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic wait_ack(input int max, output int id, output bit ok);
    ok = 1'b0;
    id = -1;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (bus.ack != '0) begin
        ok = 1'b1;
        id = enc(bus.ack);
        break;
      end
    end
  endtask

  task automatic wait_done(input int max, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < max; i++) begin
      tick(1);
      cyc = cyc + 1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_word(input int i, input logic [WIDTH-1:0] w);
    bus.req_data[i*WIDTH +: WIDTH] = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    int  id;
    int  cyc;
    bit  ok;
    int  a0;
    int  d0;
    logic [WIDTH-1:0] w;

    n_chk        = 0;
    n_pass       = 0;
    model_on     = 1'b0;
    force_busy   = 1'b0;
    rst          = 1'b1;
    en           = 1'b0;
    err_clr      = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    tick(2);
    rst      = 1'b0;
    model_on = 1'b1;

    check("rst_start_n", 64'(bus.tx_start_n), 64'd1);
    check("rst_ack",     64'(bus.ack),        64'd0);
    check("rst_done",    64'(done),           64'd0);
    check("rst_to_err",  64'(to_err),         64'd0);
    check("rst_active",  64'(active),         64'd0);
    check("rst_tx_data", 64'(bus.tx_data),    64'd0);
    check("rst_cur_id",  64'(cur_id),         64'd0);
    check("rst_done_id", 64'(done_id),        64'd0);

    // Single requester
    set_word(2, 32'hA5A5_0001);
    bus.req = 4'b0100;
    en      = 1'b1;
    wait_ack(5, id, ok);
    check("single_ack_seen", 64'(ok), 64'd1);
    check("single_ack",      64'(bus.ack), 64'b0100);
    check("single_start_n",  64'(bus.tx_start_n), 64'd0);
    check("single_tx_data",  64'(bus.tx_data), 64'hA5A5_0001);
    check("single_cur_id",   64'(cur_id), 64'd2);
    check("single_active",   64'(active), 64'd1);
    bus.req = '0;
    tick(1);
    check("single_ack_1cyc",   64'(bus.ack), 64'd0);
    check("single_start_1cyc", 64'(bus.tx_start_n), 64'd1);
    wait_done(60, cyc, ok);
    check("single_done_seen", 64'(ok), 64'd1);
    check("single_done_lat",  64'(cyc), 64'd34);
    check("single_done_id",   64'(done_id), 64'd2);
    check("single_idle",      64'(active), 64'd0);
    tick(1);
    check("single_done_pulse", 64'(done), 64'd0);

    // Round-robin with all requesters held
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_word(i, 32'h1000_0000 + 32'(i));
    bus.req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      wait_ack(60, id, ok);
      check("rr_ack_seen", 64'(ok), 64'd1);
      check("rr_order",    64'(id), 64'(t % 4));
      w = 32'h1000_0000 + 32'(t % 4);
      check("rr_tx_data",  64'(bus.tx_data), 64'(w));
      if (t == 7) bus.req = '0;
    end
    wait_done(60, cyc, ok);
    check("rr_last_done", 64'(ok), 64'd1);
    check("rr_last_id",   64'(done_id), 64'd3);

    // Start timeout: serializer never raises busy
    model_on = 1'b0;
    set_word(0, 32'hDEAD_0000);
    bus.req = 4'b0001;
    wait_ack(5, id, ok);
    check("to_ack_seen", 64'(ok), 64'd1);
    check("to_ack_id",   64'(id), 64'd0);
    bus.req = '0;
    tick(1);
    tick(7);
    check("to_early_done",   64'(done),   64'd0);
    check("to_early_err",    64'(to_err), 64'd0);
    check("to_early_active", 64'(active), 64'd1);
    tick(1);
    check("to_done",    64'(done),    64'd1);
    check("to_err_set", 64'(to_err),  64'd1);
    check("to_done_id", 64'(done_id), 64'd0);
    check("to_idle",    64'(active),  64'd0);
    tick(1);
    check("to_done_pulse", 64'(done),   64'd0);
    check("to_err_sticky", 64'(to_err), 64'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("to_err_clr", 64'(to_err), 64'd0);
    model_on = 1'b1;

    // Gating with en
    do_reset();
    en      = 1'b0;
    bus.req = 4'b0011;
    a0      = ack_cnt;
    tick(20);
    check("gate_no_ack", 64'(ack_cnt - a0), 64'd0);
    check("gate_idle",   64'(active), 64'd0);
    en = 1'b1;
    tick(1);
    check("gate_ack0", 64'(bus.ack), 64'b0001);
    bus.req = 4'b0010;
    tick(1);
    en = 1'b0;
    wait_done(60, cyc, ok);
    check("gate_done_seen", 64'(ok), 64'd1);
    check("gate_done_id",   64'(done_id), 64'd0);
    a0 = ack_cnt;
    tick(10);
    check("gate_hold_no_ack", 64'(ack_cnt - a0), 64'd0);

    // Reset during WAIT_DONE
    en = 1'b1;
    wait_ack(5, id, ok);
    check("rstmid_ack_id", 64'(id), 64'd1);
    bus.req = '0;
    tick(10);
    check("rstmid_active", 64'(active), 64'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rstmid_active0",  64'(active),         64'd0);
    check("rstmid_start_n",  64'(bus.tx_start_n), 64'd1);
    check("rstmid_ack",      64'(bus.ack),        64'd0);
    check("rstmid_done",     64'(done),           64'd0);
    check("rstmid_cur_id",   64'(cur_id),         64'd0);
    check("rstmid_tx_data",  64'(bus.tx_data),    64'd0);
    d0 = done_cnt;
    tick(40);
    check("rstmid_no_done", 64'(done_cnt - d0), 64'd0);
    bus.req = 4'b0101;
    wait_ack(20, id, ok);
    check("rstmid_ptr0", 64'(id), 64'd0);
    bus.req = '0;
    wait_done(60, cyc, ok);
    check("rstmid_done_after", 64'(ok), 64'd1);

    // Busy held in IDLE blocks grants
    force_busy = 1'b1;
    bus.req    = 4'b1000;
    a0         = ack_cnt;
    tick(15);
    check("busy_no_ack",  64'(ack_cnt - a0), 64'd0);
    check("busy_ack_now", 64'(bus.ack), 64'd0);
    force_busy = 1'b0;
    tick(1);
    check("busy_grant", 64'(bus.ack), 64'b1000);
    bus.req = '0;
    wait_done(60, cyc, ok);
    check("busy_done_seen", 64'(ok), 64'd1);
    check("busy_done_id",   64'(done_id), 64'd3);

    tick(2);
    check("ack_protocol_violations", 64'(bad_ack), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
